// File: rtl/rx_pkt_gen_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_pkt_gen_pkg : shared types and constants for the packet replayer  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package rx_pkt_gen_pkg;

  localparam int HDR_BYTES      = 2;
  localparam int END_MARKER_LEN = 0;
  localparam int DEF_RD_LAT     = 2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_PAY  = 3'd2,
    ST_GAP  = 3'd3,
    ST_FIN  = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    RD_NONE = 2'd0,
    RD_HDR0 = 2'd1,
    RD_HDR1 = 2'd2,
    RD_PAY  = 2'd3
  } rd_tag_e;

  typedef struct packed {
    rd_tag_e tag;
    logic    sop;
    logic    eop;
  } rd_slot_t;

endpackage
`default_nettype wire

// File: rtl/rx_pkt_gen_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_pkt_gen_fifo : first-word-fall-through byte buffer with occupancy |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_pkt_gen_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 10,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  assign do_push = push & ((count_q != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/rx_pkt_gen_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rx_pkt_gen_ctrl : replays a RAM packet table as a sop/eop byte stream|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module rx_pkt_gen_ctrl
  import rx_pkt_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LAT     = DEF_RD_LAT,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [15:0]           pkt_count,
  input  logic [7:0]            ipg,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_sop,
  output logic                  tx_eop,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [15:0]           sent_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic                  sop;
    logic                  eop;
    logic [DATA_WIDTH-1:0] data;
  } fifo_word_t;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [10:0]             len_q, len_d;
  logic [2:0]              hdr_hi_q, hdr_hi_d;
  logic [1:0]              hdr_cnt_q, hdr_cnt_d;
  logic [10:0]             pay_cnt_q, pay_cnt_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic [15:0]             sent_q, sent_d;
  logic                    err_q, err_d;
  logic                    stop_seen_q, stop_seen_d;
  logic                    first_hdr_q, first_hdr_d;
  rd_slot_t [RD_LAT-1:0]   pipe_q, pipe_d;
  rd_slot_t                new_slot, pipe_out;

  logic                    issue, eop_hs, stop_now, credit_ok;
  logic                    fifo_push, fifo_pop, fifo_empty;
  logic [CNT_W-1:0]        fifo_count;
  logic [7:0]              inflight;
  logic [10:0]             hdr_len;
  fifo_word_t              fifo_in, fifo_out;

  assign pipe_out  = pipe_q[RD_LAT-1];
  assign hdr_len   = {hdr_hi_q, mem_dout[7:0]};
  assign eop_hs    = tx_valid & tx_ready & tx_eop;
  assign stop_now  = stop_seen_q | stop;

  // Payload reads still travelling through the RAM pipeline count against FIFO space.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      if (pipe_q[i].tag == RD_PAY) inflight = inflight + 8'd1;
    end
    credit_ok = (8'(fifo_count) + inflight) < 8'(FIFO_DEPTH);
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    base_d      = base_q;
    len_d       = len_q;
    hdr_hi_d    = hdr_hi_q;
    hdr_cnt_d   = hdr_cnt_q;
    pay_cnt_d   = pay_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sent_d      = sent_q;
    err_d       = err_q;
    stop_seen_d = stop_seen_q;
    first_hdr_d = first_hdr_q;
    issue       = 1'b0;
    new_slot    = '0;

    if (state_q inside {ST_HDR, ST_PAY, ST_GAP}) stop_seen_d = stop_now;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_HDR;
          addr_d      = base_addr;
          base_d      = base_addr;
          hdr_cnt_d   = '0;
          sent_d      = '0;
          err_d       = 1'b0;
          stop_seen_d = 1'b0;
          first_hdr_d = 1'b1;
        end
      end
      ST_HDR: begin
        if (stop_now) begin
          state_d = ST_FIN;
        end else begin
          if (hdr_cnt_q < 2'(HDR_BYTES)) begin
            issue        = 1'b1;
            new_slot.tag = (hdr_cnt_q == 2'd0) ? RD_HDR0 : RD_HDR1;
            addr_d       = addr_q + ADDR_WIDTH'(1);
            hdr_cnt_d    = hdr_cnt_q + 2'd1;
          end
          if (pipe_out.tag == RD_HDR0) hdr_hi_d = mem_dout[2:0];
          if (pipe_out.tag == RD_HDR1) begin
            if (hdr_len == 11'(END_MARKER_LEN)) begin
              if (first_hdr_q) begin
                err_d   = 1'b1;
                state_d = ST_FIN;
              end else begin
                addr_d    = base_q;
                hdr_cnt_d = '0;
              end
            end else begin
              len_d       = hdr_len;
              pay_cnt_d   = '0;
              first_hdr_d = 1'b0;
              state_d     = ST_PAY;
            end
          end
        end
      end
      ST_PAY: begin
        if ((pay_cnt_q != len_q) && credit_ok) begin
          issue        = 1'b1;
          new_slot.tag = RD_PAY;
          new_slot.sop = (pay_cnt_q == 11'd0);
          new_slot.eop = (pay_cnt_q == len_q - 11'd1);
          addr_d       = addr_q + ADDR_WIDTH'(1);
          pay_cnt_d    = pay_cnt_q + 11'd1;
        end
        if (eop_hs) begin
          sent_d = sent_q + 16'd1;
          if (((pkt_count != 16'd0) && (sent_d == pkt_count)) || stop_now) begin
            state_d = ST_FIN;
          end else if (ipg == 8'd0) begin
            state_d   = ST_HDR;
            hdr_cnt_d = '0;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = ipg;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q <= 8'd1) begin
          state_d   = ST_HDR;
          hdr_cnt_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Leaving a run drops any reads still in the RAM pipeline.
  always_comb begin
    pipe_d = '0;
    if (state_q != ST_FIN) begin
      pipe_d[0] = new_slot;
      for (int i = 1; i < RD_LAT; i++) pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      base_q      <= '0;
      len_q       <= '0;
      hdr_hi_q    <= '0;
      hdr_cnt_q   <= '0;
      pay_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sent_q      <= '0;
      err_q       <= 1'b0;
      stop_seen_q <= 1'b0;
      first_hdr_q <= 1'b0;
      pipe_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      len_q       <= len_d;
      hdr_hi_q    <= hdr_hi_d;
      hdr_cnt_q   <= hdr_cnt_d;
      pay_cnt_q   <= pay_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sent_q      <= sent_d;
      err_q       <= err_d;
      stop_seen_q <= stop_seen_d;
      first_hdr_q <= first_hdr_d;
      pipe_q      <= pipe_d;
    end
  end

  assign fifo_push = (pipe_out.tag == RD_PAY);
  assign fifo_pop  = tx_valid & tx_ready;
  assign fifo_in   = '{sop: pipe_out.sop, eop: pipe_out.eop, data: mem_dout};

  rx_pkt_gen_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fifo_word_t))
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_in),
    .pop   (fifo_pop),
    .dout  (fifo_out),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign mem_en   = issue;
  assign mem_we   = 1'b0;
  assign mem_addr = addr_q;
  assign tx_valid = ~fifo_empty;
  assign tx_data  = tx_valid ? fifo_out.data : '0;
  assign tx_sop   = tx_valid & fifo_out.sop;
  assign tx_eop   = tx_valid & fifo_out.eop;
  assign busy     = state_q inside {ST_HDR, ST_PAY, ST_GAP};
  assign done     = (state_q == ST_FIN);
  assign err      = err_q;
  assign sent_cnt = sent_q;

endmodule
`default_nettype wire

// File: tb/tb_rx_pkt_gen_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_rx_pkt_gen_ctrl : table-driven bench with byte scoreboard         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_rx_pkt_gen_ctrl;

  localparam int AW     = 11;
  localparam int DW     = 8;
  localparam int RD_LAT = 2;
  localparam int FDEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [15:0]   pkt_count = '0;
  logic [7:0]    ipg = '0;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] tx_data;
  logic          tx_valid, tx_sop, tx_eop;
  logic          tx_ready = 1'b1;
  logic          busy, done, err;
  logic [15:0]   sent_cnt;

  always #5 clk = ~clk;

  rx_pkt_gen_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FDEPTH)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .base_addr (base_addr),
    .pkt_count (pkt_count),
    .ipg       (ipg),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_sop    (tx_sop),
    .tx_eop    (tx_eop),
    .tx_ready  (tx_ready),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .sent_cnt  (sent_cnt)
  );

  // RAM port B model with RD_LAT-cycle read latency
  logic [7:0] ram [2048];
  logic [7:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    if (mem_en) rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[RD_LAT-1];

  int pcyc = 0;
  int e0 = 0;
  always @(posedge clk) begin
    pcyc <= pcyc + 1;
    if (start) e0 <= pcyc;
  end

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
  } byte_t;

  byte_t sb[$];
  int    checks = 0;
  int    failures = 0;
  int    first_sop, last_eop, done_rel, min_gap, rx_cnt, valid_cyc;
  bit    rand_ready = 1'b0;
  logic  stall_prev = 1'b0;
  byte_t prev_b;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    int    rel;
    byte_t got;
    byte_t exp;
    if (!reset) begin
      rel = pcyc - e0;
      got = '{data: tx_data, sop: tx_sop, eop: tx_eop};
      if (done) chk("busy_with_done", busy, 0);
      if (mem_en) chk("mem_we", mem_we, 0);
      if (stall_prev) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_hold", got, prev_b);
      end
      if (tx_valid) valid_cyc++;
      if (tx_valid && tx_sop && !stall_prev && last_eop >= 0 && (rel - last_eop - 1) < min_gap)
        min_gap = rel - last_eop - 1;
      if (tx_valid && tx_ready) begin
        rx_cnt++;
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte actual=%0h required=none", tx_data);
        end else begin
          exp = sb.pop_front();
          chk("tx_byte", got, exp);
        end
        if (tx_sop && first_sop < 0) first_sop = rel;
        if (tx_eop) last_eop = rel;
      end
      if (done && done_rel < 0) done_rel = rel;
      stall_prev = tx_valid & ~tx_ready;
      prev_b     = got;
    end else begin
      stall_prev = 1'b0;
    end
  end

  typedef struct {
    string      name;
    logic [10:0] base;
    int         len;
    logic [7:0] seed;
    logic [7:0] step;
    int         pkts;
    int         ipg_v;
    bit         rnd;
    int         exp_sent;
    bit         exp_err;
    int         exp_sop;
    int         exp_eop;
    int         exp_done;
  } vec_t;

  vec_t tbl [5];

  task automatic load_table(input logic [10:0] b, input int len, input logic [7:0] seed,
                            input logic [7:0] step);
    for (int a = 0; a < 2048; a++) ram[a] = 8'h00;
    ram[b]         = 8'(len >> 8);
    ram[11'(b + 1)] = 8'(len);
    for (int i = 0; i < len; i++) ram[11'(b + 2 + i)] = seed + 8'(i) * step;
  endtask

  task automatic push_expected(input int len, input logic [7:0] seed, input logic [7:0] step,
                               input int pkts);
    for (int p = 0; p < pkts; p++)
      for (int i = 0; i < len; i++)
        sb.push_back('{data: seed + 8'(i) * step, sop: (i == 0), eop: (i == len - 1)});
  endtask

  task automatic clear_run();
    first_sop = -1;
    last_eop  = -1;
    done_rel  = -1;
    min_gap   = 1000;
    rx_cnt    = 0;
    valid_cyc = 0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int k = 0;
    while (done_rel < 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({nm, ".done_seen"}, done_rel >= 0, 1);
  endtask

  task automatic wait_bytes(input string nm, input int n, input int bound);
    int k = 0;
    while (rx_cnt < n && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk({nm, ".bytes_reached"}, rx_cnt >= n, 1);
  endtask

  task automatic run_test(input int idx);
    vec_t v;
    v = tbl[idx];
    load_table(v.base, v.len, v.seed, v.step);
    base_addr  = v.base;
    pkt_count  = 16'(v.pkts);
    ipg        = 8'(v.ipg_v);
    rand_ready = v.rnd;
    clear_run();
    push_expected(v.len, v.seed, v.step, (v.len > 0) ? v.pkts : 0);
    pulse_start();
    wait_done(v.name, 6000);
    @(negedge clk);
    chk({v.name, ".sent_cnt"}, sent_cnt, v.exp_sent);
    chk({v.name, ".err"}, err, v.exp_err);
    chk({v.name, ".done_one_cycle"}, done, 0);
    chk({v.name, ".busy_after"}, busy, 0);
    chk({v.name, ".sb_empty"}, sb.size(), 0);
    if (v.exp_sop >= 0) chk({v.name, ".sop_cycle"}, first_sop, v.exp_sop);
    if (v.exp_eop >= 0) chk({v.name, ".eop_cycle"}, last_eop, v.exp_eop);
    if (v.exp_done >= 0) chk({v.name, ".done_cycle"}, done_rel, v.exp_done);
    if (v.pkts > 1) chk({v.name, ".ipg_respected"}, min_gap >= v.ipg_v, 1);
    if (v.exp_err) chk({v.name, ".no_tx_valid"}, valid_cyc, 0);
    rand_ready = 1'b0;
    sb.delete();
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [63:0] all_outs();
    return {mem_en, mem_we, mem_addr, tx_data, tx_valid, tx_sop, tx_eop, busy, done, err, sent_cnt};
  endfunction

  initial begin
    tbl[0] = '{"basic_len4",    11'h000, 4,  8'hAA, 8'h11, 1, 0, 1'b0, 1, 1'b0, 8,  11, 12};
    tbl[1] = '{"three_pkts",    11'h000, 4,  8'hAA, 8'h11, 3, 5, 1'b0, 3, 1'b0, 8,  -1, -1};
    tbl[2] = '{"addr_wrap",     11'h7FE, 3,  8'h11, 8'h11, 1, 0, 1'b0, 1, 1'b0, 8,  10, 11};
    tbl[3] = '{"rand_ready_64", 11'h200, 64, 8'h01, 8'h07, 1, 2, 1'b1, 1, 1'b0, -1, -1, -1};
    tbl[4] = '{"marker_err",    11'h300, 0,  8'h00, 8'h00, 1, 0, 1'b0, 0, 1'b1, -1, -1, 5};

    clear_run();
    repeat (3) @(negedge clk);
    chk("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", {busy, done, tx_valid, mem_en}, 4'd0);

    for (int t = 0; t < 5; t++) run_test(t);

    // stop mid-payload: packet must finish, then no further packets
    load_table(11'h400, 20, 8'h30, 8'h03);
    base_addr = 11'h400;
    pkt_count = 16'd0;
    ipg       = 8'd0;
    clear_run();
    push_expected(20, 8'h30, 8'h03, 1);
    pulse_start();
    wait_bytes("stop_run", 10, 500);
    @(posedge clk); #1 stop = 1'b1;
    wait_done("stop_run", 500);
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("stop_run.sent_cnt", sent_cnt, 1);
    chk("stop_run.bytes", rx_cnt, 20);
    chk("stop_run.eop_seen", last_eop >= 0, 1);
    chk("stop_run.sb_empty", sb.size(), 0);
    chk("stop_run.err", err, 0);

    // reset mid-run clears everything immediately
    clear_run();
    push_expected(20, 8'h30, 8'h03, 2);
    pulse_start();
    wait_bytes("reset_run", 5, 500);
    @(posedge clk); #1 reset = 1'b1;
    #1 chk("reset_mid_run_outputs", all_outs(), 64'd0);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("reset_held_outputs", all_outs(), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(negedge clk);

    run_test(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
